// File: rtl/spi_pwm_cfg_pkg.sv
// spi_pwm_cfg_pkg
// Shared definitions for the SPI PWM configuration controller:
//   - register address map of the five 8-bit PWM configuration registers
//   - SPI frame length
//   - controller FSM state type
package spi_pwm_cfg_pkg;

  // Register address map. These are 3-bit values because the register file
  // holds only five entries.
  localparam logic [2:0] ADDR_EN_OUT_LO = 3'd0;
  localparam logic [2:0] ADDR_EN_OUT_HI = 3'd1;
  localparam logic [2:0] ADDR_EN_PWM_LO = 3'd2;
  localparam logic [2:0] ADDR_EN_PWM_HI = 3'd3;
  localparam logic [2:0] ADDR_DUTY      = 3'd4;

  // Frame layout: R/W bit, 7-bit address, 8-bit data.
  localparam int FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/spi_pwm_config_ctrl_if.sv
// spi_pwm_config_ctrl_if
// SPI pin bundle between the host (master) and the configuration
// controller (slave).
//   sclk : SPI clock, idle low (mode 0)
//   copi : controller-out / peripheral-in data, MSB first
//   ncs  : chip select, active low
//   cipo : controller-in / peripheral-out data (readback only)
interface spi_pwm_config_ctrl_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;

  modport master (output sclk, output copi, output ncs, input cipo);
  modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
// Brings one asynchronous input into the clk domain through SYNC_STAGES
// flops (SYNC_STAGES must be at least 2) and adds one history flop so that
// single-cycle rise/fall pulses can be derived from the synchronized level.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   async_in  : asynchronous input pin
//   sync_out  : synchronized level
//   rise/fall : one-cycle pulses on synchronized edges
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~hist_q;
  assign fall     = ~sync_out & hist_q;

endmodule

// File: rtl/spi_pwm_config_ctrl.sv
// spi_pwm_config_ctrl
// SPI-slave configuration controller owning the PWM peripheral's register
// file. Host write frames (16 bits, MSB first: R/W, addr[6:0], data[7:0])
// arrive asynchronously to clk and are turned into synchronous register
// updates with a one-cycle cfg_update pulse.
// Optional feature macro: SPI_READBACK_EN enables read frames, which return
// the addressed register on cipo during bits 8..15. Without it cipo is 0.
// Ports:
//   clk, rst          : system clock, asynchronous active-high reset
//   spi (slave)       : sclk / copi / ncs in, cipo out
//   en_reg_out_7_0    : register 0x00
//   en_reg_out_15_8   : register 0x01
//   en_reg_pwm_7_0    : register 0x02
//   en_reg_pwm_15_8   : register 0x03
//   pwm_duty_cycle    : register 0x04
//   cfg_update        : one-cycle pulse when a register is committed
module spi_pwm_config_ctrl
  import spi_pwm_cfg_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_pwm_config_ctrl_if.slave  spi,
  output logic [7:0]            en_reg_out_7_0,
  output logic [7:0]            en_reg_out_15_8,
  output logic [7:0]            en_reg_pwm_7_0,
  output logic [7:0]            en_reg_pwm_15_8,
  output logic [7:0]            pwm_duty_cycle,
  output logic                  cfg_update
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SHIFT  = SHIFT;
  localparam logic [1:0] ST_COMMIT = COMMIT;

  // Bit counter value that marks a frame longer than FRAME_BITS.
  localparam logic [4:0] CNT_OVERFLOW = 5'(FRAME_BITS + 1);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic copi_sync, copi_rise, copi_fall;
  logic ncs_sync, ncs_rise, ncs_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .async_in(spi.sclk),
    .sync_out(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst(rst), .async_in(spi.copi),
    .sync_out(copi_sync), .rise(copi_rise), .fall(copi_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst(rst), .async_in(spi.ncs),
    .sync_out(ncs_sync), .rise(ncs_rise), .fall(ncs_fall)
  );

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  out_lo_q, out_lo_d;
  logic [7:0]  out_hi_q, out_hi_d;
  logic [7:0]  pwm_lo_q, pwm_lo_d;
  logic [7:0]  pwm_hi_q, pwm_hi_d;
  logic [7:0]  duty_q, duty_d;
  logic        cfg_update_q, cfg_update_d;

  logic [6:0]  frame_addr;
  logic [7:0]  frame_data;
  logic        commit_ok;

  assign frame_addr = shift_q[14:8];
  assign frame_data = shift_q[7:0];
  assign commit_ok  = (cnt_q == 5'(FRAME_BITS)) && shift_q[15] &&
                      (frame_addr <= MAX_ADDR);

  // The SHIFT state is only left through ncs_rise; an sclk_rise in the
  // same cycle as ncs_rise belongs to no frame and is dropped. COMMIT also
  // accepts a new ncs_fall directly so a back-to-back frame is not lost.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    out_lo_d     = out_lo_q;
    out_hi_d     = out_hi_q;
    pwm_lo_d     = pwm_lo_q;
    pwm_hi_d     = pwm_hi_q;
    duty_d       = duty_q;
    cfg_update_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ncs_fall) begin
          cnt_d   = 5'd0;
          shift_d = 16'h0000;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (ncs_rise) begin
          state_d = ST_COMMIT;
        end else if (sclk_rise) begin
          shift_d = {shift_q[14:0], copi_sync};
          cnt_d   = (cnt_q >= CNT_OVERFLOW) ? CNT_OVERFLOW : cnt_q + 5'd1;
        end
      end

      ST_COMMIT: begin
        if (commit_ok) begin
          cfg_update_d = 1'b1;
          case (frame_addr)
            7'(ADDR_EN_OUT_LO): out_lo_d = frame_data;
            7'(ADDR_EN_OUT_HI): out_hi_d = frame_data;
            7'(ADDR_EN_PWM_LO): pwm_lo_d = frame_data;
            7'(ADDR_EN_PWM_HI): pwm_hi_d = frame_data;
            7'(ADDR_DUTY):      duty_d   = frame_data;
            default: cfg_update_d = 1'b0;
          endcase
        end
        state_d = ST_IDLE;
        if (ncs_fall) begin
          cnt_d   = 5'd0;
          shift_d = 16'h0000;
          state_d = ST_SHIFT;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 5'd0;
      shift_q      <= 16'h0000;
      out_lo_q     <= 8'h00;
      out_hi_q     <= 8'h00;
      pwm_lo_q     <= 8'h00;
      pwm_hi_q     <= 8'h00;
      duty_q       <= 8'h00;
      cfg_update_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      out_lo_q     <= out_lo_d;
      out_hi_q     <= out_hi_d;
      pwm_lo_q     <= pwm_lo_d;
      pwm_hi_q     <= pwm_hi_d;
      duty_q       <= duty_d;
      cfg_update_q <= cfg_update_d;
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign cfg_update      = cfg_update_q;

  logic unused_sync;
  assign unused_sync = ^{sclk_sync, copi_rise, copi_fall, ncs_sync};

`ifdef SPI_READBACK_EN
  logic [7:0] rd_shift_q, rd_shift_d;
  logic [6:0] rd_addr;
  logic       rd_is_read;
  logic [7:0] rd_value;

  // On the 8th sclk_rise the header byte is {shift_q[6:0], copi_sync}.
  assign rd_is_read = ~shift_q[6];
  assign rd_addr    = {shift_q[5:0], copi_sync};

  always_comb begin
    rd_value = 8'h00;
    if (rd_addr <= MAX_ADDR) begin
      case (rd_addr)
        7'(ADDR_EN_OUT_LO): rd_value = out_lo_q;
        7'(ADDR_EN_OUT_HI): rd_value = out_hi_q;
        7'(ADDR_EN_PWM_LO): rd_value = pwm_lo_q;
        7'(ADDR_EN_PWM_HI): rd_value = pwm_hi_q;
        7'(ADDR_DUTY):      rd_value = duty_q;
        default:            rd_value = 8'h00;
      endcase
    end
  end

  // The MSB is presented right after the header, so the sclk_fall that
  // follows the 8th rise must not shift; shifting resumes after the host
  // has sampled bit 8, i.e. on falls that see the counter at 9..15.
  always_comb begin
    rd_shift_d = rd_shift_q;
    if (state_q != ST_SHIFT) begin
      rd_shift_d = 8'h00;
    end else if (sclk_rise && !ncs_rise && (cnt_q == 5'd7)) begin
      rd_shift_d = rd_is_read ? rd_value : 8'h00;
    end else if (sclk_fall && (cnt_q >= 5'd9) && (cnt_q <= 5'd15)) begin
      rd_shift_d = {rd_shift_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_shift_q <= 8'h00;
    end else begin
      rd_shift_q <= rd_shift_d;
    end
  end

  assign spi.cipo = rd_shift_q[7] & (state_q == ST_SHIFT);
`else
  logic unused_rd;
  assign unused_rd = sclk_fall;
  assign spi.cipo  = 1'b0;
`endif

endmodule
